// File: rtl/lists_manager.sv
// Task-list manager for a small RTOS kernel: per-slot task state, one rank-ordered
// READY FIFO per priority, a delay list woken by the system tick, and a TCB read port.
module lists_manager #(
    parameter int MAX_TASKS = 16
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        insertnew_cmd,
    input  logic [31:0] tcb_task_in,
    input  logic [5:0]  pri_task_in,
    input  logic        insert_cmd,
    input  logic        suspend_cmd,
    input  logic        delete_cmd,
    input  logic        ins_dlylist_in,
    input  logic [7:0]  id_task_in,
    input  logic [31:0] valuedelay_in,
    input  logic [31:0] tickval_in,
    output logic [5:0]  highpriority_out,
    output logic [7:0]  ptr_hpritask_out,
    output logic [7:0]  ptr_nexttask_out,
    input  logic [7:0]  addr_read_in,
    output logic [31:0] tcb_read_out,
    output logic [7:0]  id_task_out
);

    localparam int          IW     = $clog2(MAX_TASKS);
    localparam logic [7:0]  MAX_ID = 8'(MAX_TASKS - 1);

    typedef enum logic [1:0] {FREE, READY, SUSPENDED, DELAYED} slot_state_e;
    typedef enum logic [2:0] {
        OP_NONE, OP_DELETE, OP_SUSPEND, OP_DELAY, OP_INSERT, OP_NEW, OP_WAKE
    } op_e;

    slot_state_e    state_q [MAX_TASKS];
    slot_state_e    state_d [MAX_TASKS];
    logic [31:0]    tcb_q   [MAX_TASKS];
    logic [31:0]    tcb_d   [MAX_TASKS];
    logic [5:0]     pri_q   [MAX_TASKS];
    logic [5:0]     pri_d   [MAX_TASKS];
    logic [31:0]    wake_q  [MAX_TASKS];
    logic [31:0]    wake_d  [MAX_TASKS];
    logic [IW-1:0]  rank_q  [MAX_TASKS];
    logic [IW-1:0]  rank_d  [MAX_TASKS];
    logic [7:0]     id_out_q, id_out_d;

    logic           free_found, wake_found;
    logic [IW-1:0]  free_idx, wake_idx;
    op_e            op;
    logic           tgt_ok;
    logic [IW-1:0]  tgt, act;
    slot_state_e    tgt_state;
    logic           do_remove, do_append;
    logic [5:0]     app_pri;
    logic [IW-1:0]  app_cnt;

    // Lowest-numbered FREE slot and lowest-numbered DELAYED slot due at this tick.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        wake_found = 1'b0;
        wake_idx   = '0;
        for (int i = MAX_TASKS - 1; i >= 0; i--) begin
            if (state_q[i] == FREE) begin
                free_found = 1'b1;
                free_idx   = IW'(i);
            end
            if (state_q[i] == DELAYED && wake_q[i] == tickval_in) begin
                wake_found = 1'b1;
                wake_idx   = IW'(i);
            end
        end
    end

    // NOTE: every variable gets a default at the top of the block so no path infers a latch.
    always_comb begin
        state_d  = state_q;
        tcb_d    = tcb_q;
        pri_d    = pri_q;
        wake_d   = wake_q;
        rank_d   = rank_q;
        id_out_d = id_out_q;

        tgt_ok    = (id_task_in <= MAX_ID);
        tgt       = id_task_in[IW-1:0];
        tgt_state = state_q[tgt];
        act       = tgt;
        app_pri   = pri_q[tgt];
        do_remove = 1'b0;
        do_append = 1'b0;
        app_cnt   = '0;

        // One operation per cycle; a selected but invalid command still blocks the rest.
        if (delete_cmd)          op = OP_DELETE;
        else if (suspend_cmd)    op = OP_SUSPEND;
        else if (ins_dlylist_in) op = OP_DELAY;
        else if (insert_cmd)     op = OP_INSERT;
        else if (insertnew_cmd)  op = OP_NEW;
        else if (wake_found)     op = OP_WAKE;
        else                     op = OP_NONE;

        case (op)
            OP_DELETE: begin
                if (tgt_ok && tgt_state != FREE) begin
                    do_remove    = (tgt_state == READY);
                    state_d[tgt] = FREE;
                    rank_d[tgt]  = '0;
                end
            end
            OP_SUSPEND: begin
                if (tgt_ok && tgt_state != FREE) begin
                    do_remove    = (tgt_state == READY);
                    state_d[tgt] = SUSPENDED;
                    rank_d[tgt]  = '0;
                end
            end
            OP_DELAY: begin
                if (tgt_ok && tgt_state != FREE) begin
                    do_remove    = (tgt_state == READY);
                    state_d[tgt] = DELAYED;
                    wake_d[tgt]  = valuedelay_in;
                    rank_d[tgt]  = '0;
                end
            end
            OP_INSERT: begin
                if (tgt_ok && (tgt_state == SUSPENDED || tgt_state == DELAYED)) begin
                    pri_d[tgt]   = pri_task_in;
                    app_pri      = pri_task_in;
                    state_d[tgt] = READY;
                    do_append    = 1'b1;
                end
            end
            OP_NEW: begin
                if (free_found) begin
                    act          = free_idx;
                    tcb_d[act]   = tcb_task_in;
                    pri_d[act]   = pri_task_in;
                    app_pri      = pri_task_in;
                    state_d[act] = READY;
                    do_append    = 1'b1;
                    id_out_d     = 8'(free_idx);
                end else begin
                    id_out_d     = 8'hFF;
                end
            end
            OP_WAKE: begin
                act          = wake_idx;
                app_pri      = pri_q[wake_idx];
                state_d[act] = READY;
                do_append    = 1'b1;
            end
            default: ;
        endcase

        // Close the gap left behind the removed task in its priority FIFO.
        if (do_remove) begin
            for (int j = 0; j < MAX_TASKS; j++) begin
                if (state_q[j] == READY && pri_q[j] == pri_q[tgt] && rank_q[j] > rank_q[tgt])
                    rank_d[j] = rank_q[j] - IW'(1);
            end
        end

        // The appended task is never READY beforehand, so it is not in its own count.
        if (do_append) begin
            for (int j = 0; j < MAX_TASKS; j++) begin
                if (state_q[j] == READY && pri_q[j] == app_pri)
                    app_cnt = app_cnt + IW'(1);
            end
            rank_d[act] = app_cnt;
        end
    end

    // NOTE: the slot arrays are reset explicitly because a reset must discard every list.
    always_ff @(posedge aclk) begin
        if (aresetn) begin
            for (int i = 0; i < MAX_TASKS; i++) begin
                state_q[i] <= FREE;
                tcb_q[i]   <= '0;
                pri_q[i]   <= '0;
                wake_q[i]  <= '0;
                rank_q[i]  <= '0;
            end
            id_out_q <= 8'hFF;
        end else begin
            state_q  <= state_d;
            tcb_q    <= tcb_d;
            pri_q    <= pri_d;
            wake_q   <= wake_d;
            rank_q   <= rank_d;
            id_out_q <= id_out_d;
        end
    end

    logic [5:0] hp;
    logic [7:0] hpri, nxt;
    logic       nxt_found;
    logic       rd_ok;
    logic [IW-1:0] rd_idx;

    always_comb begin
        hp = '0;
        for (int i = 0; i < MAX_TASKS; i++) begin
            if (state_q[i] == READY && pri_q[i] > hp)
                hp = pri_q[i];
        end
        hpri      = 8'hFF;
        nxt       = 8'hFF;
        nxt_found = 1'b0;
        for (int i = 0; i < MAX_TASKS; i++) begin
            if (state_q[i] == READY && pri_q[i] == hp) begin
                if (rank_q[i] == '0)
                    hpri = 8'(i);
                if (rank_q[i] == IW'(1)) begin
                    nxt       = 8'(i);
                    nxt_found = 1'b1;
                end
            end
        end
        // A single-entry FIFO reports its head as the next task as well.
        if (!nxt_found)
            nxt = hpri;
    end

    assign rd_ok  = (addr_read_in <= MAX_ID);
    assign rd_idx = addr_read_in[IW-1:0];

    assign highpriority_out = hp;
    assign ptr_hpritask_out = hpri;
    assign ptr_nexttask_out = nxt;
    assign tcb_read_out     = (rd_ok && state_q[rd_idx] != FREE) ? tcb_q[rd_idx] : 32'h0;
    assign id_task_out      = id_out_q;

endmodule

// File: tb/tb_lists_manager.sv
// Directed bench for lists_manager: stimulus pushes expected outputs into a scoreboard,
// a negedge monitor pops and compares them in the cycle after each command edge.
module tb_lists_manager;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        insertnew_cmd, insert_cmd, suspend_cmd, delete_cmd, ins_dlylist_in;
    logic [31:0] tcb_task_in, valuedelay_in, tickval_in;
    logic [5:0]  pri_task_in;
    logic [7:0]  id_task_in;
    logic [5:0]  highpriority_out;
    logic [7:0]  ptr_hpritask_out, ptr_nexttask_out, id_task_out;
    logic [31:0] tcb_read_out;

    always #5 aclk = ~aclk;

    lists_manager #(.MAX_TASKS(16)) dut (
        .aclk             (aclk),
        .aresetn          (aresetn),
        .insertnew_cmd    (insertnew_cmd),
        .tcb_task_in      (tcb_task_in),
        .pri_task_in      (pri_task_in),
        .insert_cmd       (insert_cmd),
        .suspend_cmd      (suspend_cmd),
        .delete_cmd       (delete_cmd),
        .ins_dlylist_in   (ins_dlylist_in),
        .id_task_in       (id_task_in),
        .valuedelay_in    (valuedelay_in),
        .tickval_in       (tickval_in),
        .highpriority_out (highpriority_out),
        .ptr_hpritask_out (ptr_hpritask_out),
        .ptr_nexttask_out (ptr_nexttask_out),
        .addr_read_in     (ptr_hpritask_out),
        .tcb_read_out     (tcb_read_out),
        .id_task_out      (id_task_out)
    );

    typedef struct {
        string       name;
        int          cyc;
        logic [5:0]  hp;
        logic [7:0]  hpri;
        logic [7:0]  nxt;
        logic [31:0] tcb;
        logic [7:0]  idout;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks  = 0;
    int   errors  = 0;
    int   cyc_cnt = 0;

    always @(posedge aclk) cyc_cnt <= cyc_cnt + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    // Monitor: compares the outputs in the cycle each expectation was scheduled for.
    always @(negedge aclk) begin
        if (sb.size() > 0 && sb[0].cyc <= cyc_cnt) begin
            mon_e = sb.pop_front();
            if (mon_e.cyc != cyc_cnt)
                check({mon_e.name, ".cycle"}, 32'(cyc_cnt), 32'(mon_e.cyc));
            check({mon_e.name, ".highpriority"}, 32'(highpriority_out), 32'(mon_e.hp));
            check({mon_e.name, ".hpri"},         32'(ptr_hpritask_out), 32'(mon_e.hpri));
            check({mon_e.name, ".next"},         32'(ptr_nexttask_out), 32'(mon_e.nxt));
            check({mon_e.name, ".tcb_read"},     tcb_read_out,          mon_e.tcb);
            check({mon_e.name, ".id_task"},      32'(id_task_out),      32'(mon_e.idout));
        end
    end

    task automatic expect_out(input string n, input logic [5:0] hp, input logic [7:0] h,
                              input logic [7:0] nx, input logic [31:0] t, input logic [7:0] id);
        exp_t e;
        e.name  = n;
        e.cyc   = cyc_cnt + 1;
        e.hp    = hp;
        e.hpri  = h;
        e.nxt   = nx;
        e.tcb   = t;
        e.idout = id;
        sb.push_back(e);
    endtask

    task automatic clr();
        aresetn        = 1'b0;
        insertnew_cmd  = 1'b0;
        insert_cmd     = 1'b0;
        suspend_cmd    = 1'b0;
        delete_cmd     = 1'b0;
        ins_dlylist_in = 1'b0;
        id_task_in     = 8'h00;
        tcb_task_in    = 32'h0;
        pri_task_in    = 6'h0;
        valuedelay_in  = 32'h0;
    endtask

    task automatic slot();
        @(posedge aclk);
        #1;
        clr();
    endtask

    task automatic op_reset(input bit with_new);
        slot();
        aresetn       = 1'b1;
        insertnew_cmd = with_new;
        tcb_task_in   = 32'hA5A5A5A5;
        pri_task_in   = 6'h3F;
    endtask

    task automatic op_new(input logic [31:0] t, input logic [5:0] p);
        slot();
        insertnew_cmd = 1'b1;
        tcb_task_in   = t;
        pri_task_in   = p;
    endtask

    task automatic op_ins(input logic [7:0] id, input logic [5:0] p);
        slot();
        insert_cmd  = 1'b1;
        id_task_in  = id;
        pri_task_in = p;
    endtask

    task automatic op_sus(input logic [7:0] id);
        slot();
        suspend_cmd = 1'b1;
        id_task_in  = id;
    endtask

    task automatic op_del(input logic [7:0] id);
        slot();
        delete_cmd = 1'b1;
        id_task_in = id;
    endtask

    task automatic op_dly(input logic [7:0] id, input logic [31:0] w);
        slot();
        ins_dlylist_in = 1'b1;
        id_task_in     = id;
        valuedelay_in  = w;
    endtask

    task automatic op_idle(input logic [31:0] tick);
        slot();
        tickval_in = tick;
    endtask

    initial begin
        clr();
        aresetn    = 1'b1;
        tickval_in = 32'h0;
        repeat (2) @(posedge aclk);

        op_reset(1'b1);                expect_out("reset_with_new", 6'h0,  8'hFF, 8'hFF, 32'h0,        8'hFF);
        op_new(32'hFAFFFFFF, 6'hB);    expect_out("new0",           6'hB,  8'd0,  8'd0,  32'hFAFFFFFF, 8'd0);
        op_new(32'hBBBBBBBB, 6'hB);    expect_out("new1",           6'hB,  8'd0,  8'd1,  32'hFAFFFFFF, 8'd1);
        op_new(32'hCCCCCCCC, 6'hC);    expect_out("new2_pri_c",     6'hC,  8'd2,  8'd2,  32'hCCCCCCCC, 8'd2);
        op_new(32'hDDDDDDDD, 6'hB);    expect_out("new3",           6'hC,  8'd2,  8'd2,  32'hCCCCCCCC, 8'd3);
        op_sus(8'd2);                  expect_out("suspend2",       6'hB,  8'd0,  8'd1,  32'hFAFFFFFF, 8'd3);
        op_ins(8'd2, 6'hB);            expect_out("insert2",        6'hB,  8'd0,  8'd1,  32'hFAFFFFFF, 8'd3);
        op_dly(8'd0, 32'h59);          expect_out("delay0",         6'hB,  8'd1,  8'd3,  32'hBBBBBBBB, 8'd3);
        op_idle(32'h59);               expect_out("wake0",          6'hB,  8'd1,  8'd3,  32'hBBBBBBBB, 8'd3);
        op_idle(32'h59);               expect_out("wake0_hold",     6'hB,  8'd1,  8'd3,  32'hBBBBBBBB, 8'd3);
        op_sus(8'd1);                  expect_out("order_sus1",     6'hB,  8'd3,  8'd2,  32'hDDDDDDDD, 8'd3);
        op_sus(8'd3);                  expect_out("order_sus3",     6'hB,  8'd2,  8'd0,  32'hCCCCCCCC, 8'd3);
        op_dly(8'd2, 32'hBB);          expect_out("delay2_bb",      6'hB,  8'd0,  8'd0,  32'hFAFFFFFF, 8'd3);
        op_dly(8'd3, 32'h49);          expect_out("delay3_49",      6'hB,  8'd0,  8'd0,  32'hFAFFFFFF, 8'd3);
        op_idle(32'hBB);               expect_out("wake2_only",     6'hB,  8'd0,  8'd2,  32'hFAFFFFFF, 8'd3);
        op_idle(32'h49);               expect_out("wake3",          6'hB,  8'd0,  8'd2,  32'hFAFFFFFF, 8'd3);
        op_sus(8'd0);                  expect_out("tail_check",     6'hB,  8'd2,  8'd3,  32'hCCCCCCCC, 8'd3);
        op_dly(8'd2, 32'h70);          expect_out("delay2_70",      6'hB,  8'd3,  8'd3,  32'hDDDDDDDD, 8'd3);
        op_dly(8'd3, 32'h70);          expect_out("delay3_70",      6'h0,  8'hFF, 8'hFF, 32'h0,        8'd3);
        op_idle(32'h70);               expect_out("wake_first",     6'hB,  8'd2,  8'd2,  32'hCCCCCCCC, 8'd3);
        op_idle(32'h70);               expect_out("wake_second",    6'hB,  8'd2,  8'd3,  32'hCCCCCCCC, 8'd3);
        op_sus(8'd16);                 expect_out("bad_id_sus",     6'hB,  8'd2,  8'd3,  32'hCCCCCCCC, 8'd3);
        op_del(8'hFF);                 expect_out("bad_id_del",     6'hB,  8'd2,  8'd3,  32'hCCCCCCCC, 8'd3);
        op_ins(8'd2, 6'h3F);           expect_out("ins_ready_ign",  6'hB,  8'd2,  8'd3,  32'hCCCCCCCC, 8'd3);
        op_ins(8'd9, 6'h20);           expect_out("ins_free_ign",   6'hB,  8'd2,  8'd3,  32'hCCCCCCCC, 8'd3);

        op_del(8'd2);
        insertnew_cmd = 1'b1;
        tcb_task_in   = 32'h11111111;
        pri_task_in   = 6'h3F;         expect_out("del_beats_new",  6'hB,  8'd3,  8'd3,  32'hDDDDDDDD, 8'd3);
        op_sus(8'd3);                  expect_out("suspend3",       6'h0,  8'hFF, 8'hFF, 32'h0,        8'd3);
        op_dly(8'd1, 32'h200);
        insert_cmd  = 1'b1;
        pri_task_in = 6'h5;            expect_out("dly_beats_ins",  6'h0,  8'hFF, 8'hFF, 32'h0,        8'd3);
        op_ins(8'd1, 6'h5);            expect_out("ins_from_dly",   6'h5,  8'd1,  8'd1,  32'hBBBBBBBB, 8'd3);
        op_ins(8'd0, 6'h5);            expect_out("ins_from_sus",   6'h5,  8'd1,  8'd0,  32'hBBBBBBBB, 8'd3);

        // Free slots at this point are 2 and 4..15, allocated lowest first.
        for (int i = 2; i < 16; i++) begin
            if (i != 3) begin
                op_new(32'h100 + 32'(i), 6'h1);
                expect_out("fill", 6'h5, 8'd1, 8'd0, 32'hBBBBBBBB, 8'(i));
            end
        end
        op_new(32'h99999999, 6'h9);    expect_out("new_when_full",  6'h5,  8'd1,  8'd0,  32'hBBBBBBBB, 8'hFF);
        op_del(8'd5);                  expect_out("delete5",        6'h5,  8'd1,  8'd0,  32'hBBBBBBBB, 8'hFF);
        op_new(32'h55555555, 6'h3F);   expect_out("reuse5",         6'h3F, 8'd5,  8'd5,  32'h55555555, 8'd5);
        op_reset(1'b0);                expect_out("mid_reset",      6'h0,  8'hFF, 8'hFF, 32'h0,        8'hFF);
        op_new(32'h12345678, 6'h7);    expect_out("new_after_rst",  6'h7,  8'd0,  8'd0,  32'h12345678, 8'd0);
        op_idle(32'h70);

        for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge aclk);
        #1;
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain pending %0d expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lists_manager.md
LISTS_MANAGER -- requirements
Module: lists_manager

Interface
REQ-001 Parameter MAX_TASKS, default 16, number of task slots; task ids are 0..MAX_TASKS-1.
REQ-002 aclk  in  1  single clock; all state updates on its rising edge.
REQ-003 aresetn  in  1  reset; synchronous, active-high: a 1 sampled on a rising aclk edge resets the block.
REQ-004 insertnew_cmd  in  1  one-cycle pulse: create a task from tcb_task_in and pri_task_in.
REQ-005 tcb_task_in  in  32  TCB pointer for the new task.
REQ-006 pri_task_in  in  6  task priority; larger value means higher priority.
REQ-007 insert_cmd  in  1  pulse: make task id_task_in ready at priority pri_task_in.
REQ-008 suspend_cmd  in  1  pulse: suspend task id_task_in.
REQ-009 delete_cmd  in  1  pulse: delete task id_task_in and free its slot.
REQ-010 ins_dlylist_in  in  1  pulse: move task id_task_in to the delay list.
REQ-011 id_task_in  in  8  target task id for insert, suspend, delete and delay.
REQ-012 valuedelay_in  in  32  absolute wake tick for a delay insertion.
REQ-013 tickval_in  in  32  current system tick value.
REQ-014 highpriority_out  out  6  highest priority among ready tasks.
REQ-015 ptr_hpritask_out  out  8  id at the head of the highest-priority ready FIFO.
REQ-016 ptr_nexttask_out  out  8  id that follows the head in that FIFO.
REQ-017 addr_read_in  in  8  task id used for the TCB read port.
REQ-018 tcb_read_out  out  32  TCB pointer of task addr_read_in.
REQ-019 id_task_out  out  8  id allocated by the last insertnew_cmd.

Function
REQ-020 Each slot SHALL hold: tcb[31:0], pri[5:0], wake[31:0], rank, and a state from {FREE, READY, SUSPENDED, DELAYED}.
REQ-021 Each priority SHALL have one FIFO of READY tasks, ordered by rank: rank 0 is the head, and the rank of a newly appended task equals the count of READY tasks already at that priority.
REQ-022 Removing a task from READY SHALL decrement the rank of every READY task at the same priority whose rank is greater than the removed task's rank.
REQ-023 insertnew_cmd SHALL take the lowest-numbered FREE slot, store tcb and pri, set state READY, append the task, and set id_task_out to the slot id one cycle later.
REQ-024 When no slot is FREE, insertnew_cmd SHALL leave all state unchanged and set id_task_out to 0xFF.
REQ-025 insert_cmd on a SUSPENDED or DELAYED task SHALL set pri to pri_task_in, set state READY and append the task.
REQ-026 insert_cmd on a FREE or READY task SHALL be ignored.
REQ-027 suspend_cmd SHALL remove the task from READY if it is READY and set state SUSPENDED.
REQ-028 suspend_cmd on a FREE task SHALL be ignored.
REQ-029 delete_cmd SHALL remove the task from any list and set state FREE.
REQ-030 ins_dlylist_in on a non-FREE task SHALL remove it from READY if applicable, set wake=valuedelay_in and set state DELAYED.
REQ-031 Wake: when a cycle has no command and tickval_in equals the wake value of a DELAYED task, the lowest-id such task SHALL become READY at its stored pri and be appended.
REQ-032 Only one task SHALL wake per cycle; the remaining matching tasks SHALL wake on the following cycles while tickval_in holds its value.
REQ-033 Only one operation SHALL execute per cycle, chosen in priority order: delete > suspend > ins_dlylist > insert > insertnew > wake; the other requests in that cycle are dropped.
REQ-034 An id_task_in value >= MAX_TASKS SHALL make the command a no-op.
REQ-035 Command results SHALL be visible on the outputs one cycle after the command edge.
REQ-036 highpriority_out, ptr_hpritask_out and ptr_nexttask_out SHALL be combinational from registered state.
REQ-037 ptr_hpritask_out SHALL be the rank-0 task at highpriority_out.
REQ-038 ptr_nexttask_out SHALL be the rank-1 task at highpriority_out, or equal to ptr_hpritask_out when that priority has only one READY task.
REQ-039 With no READY task: highpriority_out=0, ptr_hpritask_out=0xFF, ptr_nexttask_out=0xFF.
REQ-040 tcb_read_out SHALL be combinational: tcb[addr_read_in] when the slot is non-FREE, else 0, including when addr_read_in >= MAX_TASKS.

Reset
REQ-041 Reset SHALL set all slots FREE and all tcb, pri, wake and rank to 0.
REQ-042 Reset SHALL set id_task_out to 0xFF, giving highpriority_out=0, ptr outputs 0xFF and tcb_read_out=0.
REQ-043 Reset SHALL override any command issued in the same cycle.
REQ-044 Reset asserted in the middle of a command sequence SHALL discard all lists.

Verification (addr_read_in tied to ptr_hpritask_out)
REQ-045 Insertnew of tcb FAFFFFFF, BBBBBBBB, DDDDDDDD at pri 0xB and CCCCCCCC at pri 0xC -> ids 0,1,3 and 2 respectively; highpriority_out=0xC, hpri=2, next=2, tcb_read_out=CCCCCCCC.
REQ-046 Suspend id 2 -> highpriority_out=0xB, hpri=0, next=1, tcb_read_out=FAFFFFFF.
REQ-047 Insert id 2 at pri 0xB -> FIFO order at 0xB is 0,1,3,2.
REQ-048 Delay id 0 with wake 0x59 -> hpri=1, next=3; then with tickval_in=0x59 held for 2 cycles -> id 0 is READY again at the FIFO tail.
REQ-049 Delay ids 2 (wake 0xBB) and 3 (wake 0x49) on consecutive cycles, then set tickval_in=0xBB -> only id 2 wakes; then set tickval_in=0x49 -> id 3 wakes.
REQ-050 Fill all 16 slots, issue a 17th insertnew -> id_task_out=0xFF; delete id 5, then insertnew -> id_task_out=5.
REQ-051 delete_cmd and insertnew_cmd in the same cycle -> only the delete executes.
